// File: rtl/pac_mp.sv
// pac_mp - packet action controller.
//
// Purpose:
//   Applies the per-packet action chosen upstream. Each packet can go to ibm
//   with a TSN metadata word, to any subset of PORT_NUM local ports, or be
//   discarded. Admission to ibm needs enough free buffer IDs for the packet's
//   priority, looked up in THR_TABLE. Every accepted word appears on its
//   destinations two cycles after its input strobe: one delay stage plus the
//   output register.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_pac_data/_wr        packet word and word strobe; tag in [DW-1:DW-2]
//   in_pac_valid/_wr       packet good flag and its strobe (with the tail)
//   in_pac_action/_wr      {pri, to_ibm, port_mask, tsn_flag} and its strobe
//   bufm_ID_count          free buffer IDs reported by ibm
//   out_pac_*              ibm word, valid and TSN metadata outputs
//   out_port_*             shared local-port word bus, per-port strobes/valids
//   pkt_out_cnt            delivered packets, summed over all destinations
//   bufm_ID_cnt            registered, zero-extended bufm_ID_count
//   drop_cnt               dropped-packet count (PAC_MP_DROP_CNT_EN only)
//
// Optional feature: define PAC_MP_DROP_CNT_EN to add the drop_cnt output.

module pac_mp #(
    parameter int DW = 134,
    parameter int PORT_NUM = 4,
    parameter int ID_W = 5,
    parameter logic [8*ID_W-1:0] THR_TABLE = {{6{ID_W'(1)}}, ID_W'(3), ID_W'(4)}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         in_pac_data,
    input  logic                  in_pac_data_wr,
    input  logic                  in_pac_valid,
    input  logic                  in_pac_valid_wr,
    input  logic [PORT_NUM+4:0]   in_pac_action,
    input  logic                  in_pac_action_wr,
    input  logic [ID_W-1:0]       bufm_ID_count,
    output logic [DW-1:0]         out_pac_data,
    output logic                  out_pac_data_wr,
    output logic                  out_pac_valid,
    output logic                  out_pac_valid_wr,
    output logic [23:0]           out_pac_tsn_md,
    output logic                  out_pac_tsn_md_wr,
    output logic [DW-1:0]         out_port_data,
    output logic [PORT_NUM-1:0]   out_port_data_wr,
    output logic [PORT_NUM-1:0]   out_port_valid,
    output logic [PORT_NUM-1:0]   out_port_valid_wr,
    output logic [63:0]           pkt_out_cnt,
    output logic [7:0]            bufm_ID_cnt
`ifdef PAC_MP_DROP_CNT_EN
    ,
    output logic [31:0]           drop_cnt
`endif
);

    localparam int AW    = PORT_NUM + 5;
    localparam int NDEST = PORT_NUM + 1;   // bit PORT_NUM is ibm, below are ports

    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DISC = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    act_q, act_cur;
    logic [1:0]       tag;
    logic             is_head, is_tail;
    logic [2:0]       pri;
    logic [ID_W-1:0]  thr;
    logic             to_ibm, ibm_en;
    logic [NDEST-1:0] new_dest, dest_q, cur_dest;
    logic             accept, abort, head_acc;
    logic             pvld_cur, pvld_q;

    // delay stage
    logic             vld_p0_q, tail_p0_q, pvld_p0_q, mdwr_p0_q;
    logic [NDEST-1:0] dest_p0_q;
    logic [DW-1:0]    data_p0_q;
    logic [23:0]      md_p0_q;

    // output-stage decode
    logic             ibm_wr;
    logic [PORT_NUM-1:0] port_wr;
    logic [NDEST-1:0] tail_dest, vwr_dest, vld_dest;

    function automatic logic [7:0] popcnt(input logic [NDEST-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < NDEST; i++) n = n + 8'(v[i]);
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Decode of the incoming word and action
    // ------------------------------------------------------------------
    assign tag      = in_pac_data[DW-1:DW-2];
    assign is_head  = (tag == 2'b01) || (tag == 2'b00);
    assign is_tail  = (tag == 2'b10) || (tag == 2'b00);
    assign act_cur  = in_pac_action_wr ? in_pac_action : act_q;
    assign pri      = act_cur[PORT_NUM+4:PORT_NUM+2];
    assign to_ibm   = act_cur[PORT_NUM+1];
    assign thr      = THR_TABLE[int'(pri)*ID_W +: ID_W];
    assign ibm_en   = to_ibm && !(bufm_ID_count < thr);
    assign new_dest = {ibm_en, act_cur[PORT_NUM:1]};
    // A valid strobe anywhere in the packet overrides the default of "good".
    assign pvld_cur = in_pac_valid_wr ? in_pac_valid : (is_head ? 1'b1 : pvld_q);
    assign head_acc = in_pac_data_wr && is_head;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (in_pac_data_wr) begin
            if (is_head) begin
                if (tag == 2'b00)           state_d = IDLE;
                else if (new_dest != '0)    state_d = FWD;
                else                        state_d = DISC;
            end else if ((state_q != IDLE) && is_tail) begin
                state_d = IDLE;
            end
        end
    end

    // FSM: outputs. A head always starts a new packet; a head arriving while
    // a packet is still open also closes the old one as bad.
    always_comb begin
        accept   = 1'b0;
        abort    = 1'b0;
        cur_dest = dest_q;
        if (in_pac_data_wr) begin
            if (is_head) begin
                accept   = 1'b1;
                abort    = (state_q != IDLE);
                cur_dest = new_dest;
            end else if (state_q != IDLE) begin
                accept   = 1'b1;
            end
        end
    end

    // Packet context: action register, destinations and good flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= '0;
            dest_q <= '0;
            pvld_q <= 1'b1;
        end else begin
            if (in_pac_action_wr) act_q <= in_pac_action;
            if (head_acc)         dest_q <= new_dest;
            if (accept)           pvld_q <= pvld_cur;
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: delay stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q  <= 1'b0;
            tail_p0_q <= 1'b0;
            pvld_p0_q <= 1'b0;
            mdwr_p0_q <= 1'b0;
            dest_p0_q <= '0;
        end else begin
            vld_p0_q  <= accept && (cur_dest != '0);
            tail_p0_q <= is_tail;
            pvld_p0_q <= pvld_cur;
            mdwr_p0_q <= head_acc && ibm_en;
            dest_p0_q <= cur_dest;
        end
    end

    always_ff @(posedge clk) begin
        data_p0_q <= in_pac_data;
        md_p0_q   <= {pri, in_pac_data[107:96], act_cur[0], 8'h00};
    end

    // ------------------------------------------------------------------
    // Stage p1: output register
    // ------------------------------------------------------------------
    assign ibm_wr    = vld_p0_q && dest_p0_q[PORT_NUM];
    assign port_wr   = vld_p0_q ? dest_p0_q[PORT_NUM-1:0] : '0;
    assign tail_dest = (vld_p0_q && tail_p0_q) ? dest_p0_q : '0;
    // An aborted packet is closed on its old destinations with valid low.
    assign vwr_dest  = tail_dest | (abort ? dest_q : '0);
    assign vld_dest  = pvld_p0_q ? tail_dest : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pac_data      <= '0;
            out_pac_data_wr   <= 1'b0;
            out_pac_valid     <= 1'b0;
            out_pac_valid_wr  <= 1'b0;
            out_pac_tsn_md    <= '0;
            out_pac_tsn_md_wr <= 1'b0;
            out_port_data     <= '0;
            out_port_data_wr  <= '0;
            out_port_valid    <= '0;
            out_port_valid_wr <= '0;
            pkt_out_cnt       <= '0;
            bufm_ID_cnt       <= '0;
        end else begin
            out_pac_data      <= ibm_wr ? data_p0_q : '0;
            out_pac_data_wr   <= ibm_wr;
            out_pac_valid     <= vld_dest[PORT_NUM];
            out_pac_valid_wr  <= vwr_dest[PORT_NUM];
            out_pac_tsn_md    <= (vld_p0_q && mdwr_p0_q) ? md_p0_q : '0;
            out_pac_tsn_md_wr <= vld_p0_q && mdwr_p0_q;
            out_port_data     <= (port_wr != '0) ? data_p0_q : '0;
            out_port_data_wr  <= port_wr;
            out_port_valid    <= vld_dest[PORT_NUM-1:0];
            out_port_valid_wr <= vwr_dest[PORT_NUM-1:0];
            pkt_out_cnt       <= pkt_out_cnt + 64'(popcnt(tail_dest));
            bufm_ID_cnt       <= 8'(bufm_ID_count);
        end
    end

`ifdef PAC_MP_DROP_CNT_EN
    logic [1:0] drop_inc;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Refused ibm admission and a fully discarded packet each count once.
    assign drop_inc = {1'b0, head_acc && to_ibm && !ibm_en} +
                      {1'b0, head_acc && (new_dest == '0)};

    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else     drop_cnt <= sat_add32(drop_cnt, drop_inc);
    end
`endif

endmodule

// File: tb/tb_pac_mp.sv
module tb_pac_mp;
    localparam int DW = 134;
    localparam int PN = 4;
    localparam int NC = 8192;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] in_d;
    logic in_wr, in_v, in_vwr, act_wr;
    logic [PN+4:0] act_i;
    logic [4:0] bufm;
    logic [DW-1:0] o_pdata, o_odata;
    logic o_pwr, o_pv, o_pvwr, o_mdwr;
    logic [23:0] o_md;
    logic [PN-1:0] o_owr, o_ov, o_ovwr;
    logic [63:0] o_cnt;
    logic [7:0] o_bid;
`ifdef PAC_MP_DROP_CNT_EN
    logic [31:0] o_drop;
`endif

    pac_mp dut (
        .clk(clk), .rst(rst),
        .in_pac_data(in_d), .in_pac_data_wr(in_wr),
        .in_pac_valid(in_v), .in_pac_valid_wr(in_vwr),
        .in_pac_action(act_i), .in_pac_action_wr(act_wr),
        .bufm_ID_count(bufm),
        .out_pac_data(o_pdata), .out_pac_data_wr(o_pwr),
        .out_pac_valid(o_pv), .out_pac_valid_wr(o_pvwr),
        .out_pac_tsn_md(o_md), .out_pac_tsn_md_wr(o_mdwr),
        .out_port_data(o_odata), .out_port_data_wr(o_owr),
        .out_port_valid(o_ov), .out_port_valid_wr(o_ovwr),
        .pkt_out_cnt(o_cnt), .bufm_ID_cnt(o_bid)
`ifdef PAC_MP_DROP_CNT_EN
        , .drop_cnt(o_drop)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle, filled in by the reference model.
    logic          e_pwr [NC];
    logic [DW-1:0] e_pdata [NC];
    logic          e_pvwr [NC];
    logic          e_pv [NC];
    logic          e_mdwr [NC];
    logic [23:0]   e_md [NC];
    logic [PN-1:0] e_owr [NC];
    logic [DW-1:0] e_odata [NC];
    logic [PN-1:0] e_ovwr [NC];
    logic [PN-1:0] e_ov [NC];
    int            cnt_add [NC];
    int            drop_add [NC];
    logic [7:0]    bid_e [NC];
    bit            rstc [NC];

    // Reference model state at packet level.
    bit            open_pkt = 0;
    bit            cur_ibm = 0;
    logic [PN-1:0] cur_ports = '0;
    bit            pkt_v = 1;
    logic [PN+4:0] act_reg = '0;
    longint        m_cnt = 0;
    longint        m_drop = 0;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    bit chk_on = 0;

    function automatic int thr_of(input int p);
        if (p == 0) return 4;
        if (p == 1) return 3;
        return 1;
    endfunction

    function automatic int ones(input logic [PN-1:0] v);
        int n = 0;
        for (int i = 0; i < PN; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic clear_from(input int c);
        for (int k = c; k < NC; k++) begin
            e_pwr[k] = 0; e_pdata[k] = '0; e_pvwr[k] = 0; e_pv[k] = 0;
            e_mdwr[k] = 0; e_md[k] = '0; e_owr[k] = '0; e_odata[k] = '0;
            e_ovwr[k] = '0; e_ov[k] = '0; cnt_add[k] = 0; drop_add[k] = 0;
            bid_e[k] = '0; rstc[k] = 0;
        end
    endtask

    // Applies the packet rules to the inputs driven in the current cycle.
    task automatic model_cycle();
        int c;
        logic [1:0] tg;
        bit hd, tl, acc, ibm;
        logic [PN+4:0] a;
        int pri;
        c = cyc;
        bid_e[c+1] = rst ? 8'd0 : {3'b000, bufm};
        if (rst) begin
            clear_from(c + 1);
            rstc[c+1] = 1;
            open_pkt = 0;
            act_reg = '0;
            return;
        end
        if (in_wr) begin
            tg = in_d[DW-1:DW-2];
            hd = (tg == 2'b01) || (tg == 2'b00);
            tl = (tg == 2'b10) || (tg == 2'b00);
            acc = open_pkt;
            if (hd) begin
                if (open_pkt) begin
                    if (cur_ibm) e_pvwr[c+1] = 1;
                    e_ovwr[c+1] = e_ovwr[c+1] | cur_ports;
                end
                a = act_wr ? act_i : act_reg;
                pri = int'(a[8:6]);
                ibm = a[5] && (int'(bufm) >= thr_of(pri));
                cur_ibm = ibm;
                cur_ports = a[4:1];
                drop_add[c+1] = ((a[5] && !ibm) ? 1 : 0) + ((!ibm && cur_ports == 0) ? 1 : 0);
                open_pkt = (tg != 2'b00);
                pkt_v = 1;
                if (ibm) begin
                    e_mdwr[c+2] = 1;
                    e_md[c+2] = {a[8:6], in_d[107:96], a[0], 8'h00};
                end
                acc = 1;
            end
            if (acc) begin
                if (in_vwr) pkt_v = in_v;
                if (cur_ibm) begin e_pwr[c+2] = 1; e_pdata[c+2] = in_d; end
                if (cur_ports != 0) begin e_owr[c+2] = cur_ports; e_odata[c+2] = in_d; end
                if (tl) begin
                    if (cur_ibm) begin e_pvwr[c+2] = 1; e_pv[c+2] = pkt_v; end
                    e_ovwr[c+2] = cur_ports;
                    e_ov[c+2] = pkt_v ? cur_ports : '0;
                    cnt_add[c+2] = (cur_ibm ? 1 : 0) + ones(cur_ports);
                    open_pkt = 0;
                end
            end
        end
        if (act_wr) act_reg = act_i;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && cyc < NC) begin
            if (rstc[cyc]) begin m_cnt = 0; m_drop = 0; end
            m_cnt = m_cnt + cnt_add[cyc];
            m_drop = m_drop + drop_add[cyc];
            if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
            chk("ibm_wr",   256'(o_pwr),   256'(e_pwr[cyc]));
            chk("ibm_data", 256'(o_pdata), 256'(e_pdata[cyc]));
            chk("ibm_vwr",  256'(o_pvwr),  256'(e_pvwr[cyc]));
            chk("ibm_v",    256'(o_pv),    256'(e_pv[cyc]));
            chk("md_wr",    256'(o_mdwr),  256'(e_mdwr[cyc]));
            chk("md",       256'(o_md),    256'(e_md[cyc]));
            chk("port_wr",  256'(o_owr),   256'(e_owr[cyc]));
            chk("port_data",256'(o_odata), 256'(e_odata[cyc]));
            chk("port_vwr", 256'(o_ovwr),  256'(e_ovwr[cyc]));
            chk("port_v",   256'(o_ov),    256'(e_ov[cyc]));
            chk("pkt_cnt",  256'(o_cnt),   256'(m_cnt));
            chk("bid_cnt",  256'(o_bid),   256'(bid_e[cyc]));
`ifdef PAC_MP_DROP_CNT_EN
            chk("drop_cnt", 256'(o_drop),  256'(m_drop));
`endif
        end
    end

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_wr = 0; in_d = '0; in_v = 0; in_vwr = 0; act_wr = 0; act_i = '0;
    endtask

    function automatic logic [DW-1:0] rword(input logic [1:0] tg);
        logic [159:0] r;
        logic [DW-1:0] w;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        w = r[DW-1:0];
        w[DW-1:DW-2] = tg;
        return w;
    endfunction

    function automatic logic [PN+4:0] mkact(input int pri, input bit ibm, input logic [PN-1:0] mask, input bit tsn);
        return {3'(pri), ibm, mask, tsn};
    endfunction

    task automatic send_pkt(input int nw, input logic [PN+4:0] a, input bit awr, input bit v,
                            input bit vwr, input int gapmax, input bit trunc);
        int last;
        logic [1:0] tg;
        last = trunc ? nw - 1 : nw;
        for (int i = 0; i < last; i++) begin
            if (nw == 1)           tg = 2'b00;
            else if (i == 0)       tg = 2'b01;
            else if (i == nw - 1)  tg = 2'b10;
            else                   tg = 2'b11;
            idle_in();
            in_wr = 1;
            in_d = rword(tg);
            if (i == 0 && awr) begin act_wr = 1; act_i = a; end
            if ((tg == 2'b10 || tg == 2'b00) && vwr) begin in_vwr = 1; in_v = v; end
            tick();
            idle_in();
            for (int g = $urandom_range(0, gapmax); g > 0; g--) tick();
        end
    endtask

    task automatic word(input logic [1:0] tg);
        idle_in();
        in_wr = 1;
        in_d = rword(tg);
        tick();
        idle_in();
    endtask

    initial begin
        clear_from(0);
        idle_in();
        rst = 1;
        bufm = 5'd0;
        tick();
        chk_on = 1;
        tick();
        rst = 0;
        tick();

        // 4-word packet to ibm only
        bufm = 5'd5;
        send_pkt(4, mkact(2, 1, 4'b0000, 1), 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // ibm refused, ports 0 and 2; action taken from the register
        bufm = 5'd3;
        act_i = mkact(0, 1, 4'b0101, 0); act_wr = 1;
        tick();
        idle_in();
        tick();
        send_pkt(4, '0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // discarded packet
        bufm = 5'd2;
        send_pkt(3, mkact(1, 1, 4'b0000, 0), 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // back-to-back packets without bubble
        bufm = 5'd5;
        send_pkt(2, mkact(2, 1, 4'b0000, 0), 1, 1, 1, 0, 0);
        send_pkt(2, mkact(3, 1, 4'b0000, 1), 1, 0, 1, 0, 0);
        send_pkt(1, mkact(2, 1, 4'b0000, 0), 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // missing tail: second head aborts the first packet
        idle_in(); in_wr = 1; in_d = rword(2'b01); act_wr = 1;
        act_i = mkact(4, 1, 4'b0011, 0);
        tick();
        word(2'b11);
        send_pkt(3, mkact(5, 1, 4'b1000, 1), 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // reset mid-packet, stray body words afterwards
        send_pkt(3, mkact(2, 1, 4'b0110, 0), 1, 1, 1, 0, 1);
        rst = 1; tick(); rst = 0;
        word(2'b11);
        word(2'b10);
        send_pkt(2, mkact(2, 1, 4'b0001, 0), 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // randomized traffic
        for (int p = 0; p < 250; p++) begin
            logic [PN+4:0] a;
            bit awr;
            int nw;
            bufm = 5'($urandom_range(0, 31));
            a = 9'($urandom);
            awr = ($urandom_range(0, 2) != 0);
            if (!awr && $urandom_range(0, 1) == 1) begin
                idle_in(); act_wr = 1; act_i = a; tick(); idle_in();
            end
            if ($urandom_range(0, 9) == 0) word(2'b11);
            nw = $urandom_range(1, 5);
            send_pkt(nw, a, awr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                     ($urandom_range(0, 1) == 0) ? 0 : 2, (nw > 1) && ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1; tick(); rst = 0;
            end
        end
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
